// File: rtl/pong_pkg.sv
// Shared definitions for the match timer: state encoding, default parameter
// values and the saturating set-time adjustment used by the controller.
package pong_pkg;

  // Width of every seconds-valued quantity (max_time, remaining_time).
  localparam int unsigned TIME_W = 8;

  // Default parameter values for match_timer.
  localparam int unsigned DEF_CLK_HZ          = 100_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_STEP_S          = 15;
  localparam int unsigned DEF_MIN_S           = 15;
  localparam int unsigned DEF_MAX_S           = 240;
  localparam int unsigned DEF_DEFAULT_S       = 60;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Applies one up/down step to the configured time, clamped to
  // [min_s, max_s]. Both buttons together cancel out. The sum is taken one
  // bit wider so that a step past 255 still clamps instead of wrapping.
  function automatic logic [TIME_W-1:0] adjust_time(
    input logic [TIME_W-1:0] cur,
    input logic              up,
    input logic              down,
    input logic [TIME_W-1:0] step,
    input logic [TIME_W-1:0] min_s,
    input logic [TIME_W-1:0] max_s
  );
    logic [TIME_W:0] sum;
    logic [TIME_W:0] lower_lim;
    sum       = {1'b0, cur} + {1'b0, step};
    lower_lim = {1'b0, min_s} + {1'b0, step};
    adjust_time = cur;
    if (up && !down) begin
      adjust_time = (sum > {1'b0, max_s}) ? max_s : sum[TIME_W-1:0];
    end else if (down && !up) begin
      adjust_time = ({1'b0, cur} < lower_lim) ? min_s : (cur - step);
    end
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Conditions one raw push-button into a single-cycle press pulse.
//   clk, rst_n : system clock, asynchronous active-low reset
//   btn_raw    : asynchronous, bouncing button level
//   pulse      : one-cycle high pulse per accepted press (rising edge of the
//                debounced level)
// The raw level goes through a 2-flop synchronizer; the debounced level only
// follows the synchronized level once it has differed for DEBOUNCE_CYCLES
// consecutive cycles.
module btn_pulse
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;   // sync_q[1] is the usable level
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    sync_d   = {sync_q[0], btn_raw};
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      // Count consecutive cycles the input disagrees with the accepted level;
      // any agreement restarts the count, so glitches never get through.
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    pulse_d = stable_d & ~stable_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/match_timer.sv
// Match countdown timer with a settable match length.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   btn_up/btn_down : raw buttons, adjust max_time by STEP_S while in SET
//   btn_start       : raw button, start (SET), resume (PAUSE), back to SET (DONE)
//   btn_pause       : raw button, pause (RUN) / resume (PAUSE)
//   max_time        : configured match length in seconds
//   remaining_time  : seconds left in the match
//   running         : high only while counting down
//   time_up         : one-cycle pulse in the cycle remaining_time reaches 0
module match_timer
  import pong_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STEP_S          = DEF_STEP_S,
  parameter int unsigned MIN_S           = DEF_MIN_S,
  parameter int unsigned MAX_S           = DEF_MAX_S,
  parameter int unsigned DEFAULT_S       = DEF_DEFAULT_S
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_start,
  input  logic              btn_pause,
  output logic [TIME_W-1:0] max_time,
  output logic [TIME_W-1:0] remaining_time,
  output logic              running,
  output logic              time_up
);

  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [TIME_W-1:0]  STEP_V     = TIME_W'(STEP_S);
  localparam logic [TIME_W-1:0]  MIN_V      = TIME_W'(MIN_S);
  localparam logic [TIME_W-1:0]  MAX_V      = TIME_W'(MAX_S);
  localparam logic [TIME_W-1:0]  DEFAULT_V  = TIME_W'(DEFAULT_S);

  logic up_p, down_p, start_p, pause_p;

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_up), .pulse(up_p)
  );
  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_down), .pulse(down_p)
  );
  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_start), .pulse(start_p)
  );
  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_pause (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_pause), .pulse(pause_p)
  );

  state_e             state_q, state_d;
  logic [TIME_W-1:0]  max_time_q, max_time_d;
  logic [TIME_W-1:0]  remaining_q, remaining_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               running_q, running_d;
  logic               time_up_q, time_up_d;
  logic               tick;

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    state_d     = state_q;
    max_time_d  = max_time_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    time_up_d   = 1'b0;
    case (state_q)
      ST_SET: begin
        // remaining_time shadows max_time one cycle late, which also makes
        // it equal to max_time on the cycle a start is accepted.
        remaining_d = max_time_q;
        if (start_p) begin
          presc_d = '0;
          state_d = ST_RUN;
        end else begin
          max_time_d = adjust_time(max_time_q, up_p, down_p, STEP_V, MIN_V, MAX_V);
        end
      end
      ST_RUN: begin
        // The prescaler advances on every RUN cycle, including the one in
        // which a pause is accepted; the held value therefore counts it.
        if (tick) begin
          presc_d = '0;
          if (remaining_q <= TIME_W'(1)) begin
            remaining_d = '0;
            time_up_d   = 1'b1;
            state_d     = ST_DONE;
          end else begin
            remaining_d = remaining_q - TIME_W'(1);
            if (pause_p) state_d = ST_PAUSE;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
          if (pause_p) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_p || start_p) state_d = ST_RUN;
      end
      ST_DONE: begin
        remaining_d = '0;
        if (start_p) begin
          state_d     = ST_SET;
          remaining_d = max_time_q;
        end
      end
      default: state_d = ST_SET;
    endcase
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SET;
      max_time_q  <= DEFAULT_V;
      remaining_q <= DEFAULT_V;
      presc_q     <= '0;
      running_q   <= 1'b0;
      time_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_time_q  <= max_time_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      running_q   <= running_d;
      time_up_q   <= time_up_d;
    end
  end

  assign max_time       = max_time_q;
  assign remaining_time = remaining_q;
  assign running        = running_q;
  assign time_up        = time_up_q;

endmodule
